// File: rtl/hs_arb_pkg.sv
// Shared types and widths for the hiscore work-RAM arbiter.
// Optional timeout abort is enabled by defining HS_ARB_TIMEOUT_EN.
package hs_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        WAIT_VBL,
        GRANT,
        RELEASE
    } hs_arb_state_t;

    localparam int HS_AW_DEF = 12;
    localparam int HS_DW_DEF = 8;
    localparam int HS_TO_W   = 20;

endpackage

// File: rtl/hs_arb_timer.sv
// Loadable down-counter shared by the release guard and halt timeout.
// expired is high once the count has reached zero.
module hs_arb_timer
    import hs_arb_pkg::*;
#(
    parameter int W = HS_TO_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/hs_ram_arbiter.sv
// Shares the work RAM between the CPU and the hiscore engine.
// Define HS_ARB_TIMEOUT_EN to abort stalled halt/vblank waits.
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int AW      = HS_AW_DEF,
    parameter int DW      = HS_DW_DEF,
    parameter int GUARD   = 4,
    parameter int TIMEOUT = 2**20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    output logic          hs_gnt,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_rvalid,
    output logic          pause_req,
    input  logic          pause_ack,
    input  logic          vblank,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
`ifdef HS_ARB_TIMEOUT_EN
    ,
    output logic          timeout
`endif
);

    localparam logic [HS_TO_W-1:0] GUARD_LD =
        HS_TO_W'(GUARD - 1);
    localparam logic [HS_TO_W-1:0] TO_LD =
        HS_TO_W'(TIMEOUT - 1);

    hs_arb_state_t state;

    logic tmr_load;
    logic tmr_exp;
    logic to_hit;
    logic in_wait;
    logic halt_entry;
    logic rel_entry;
    logic gnt_entry;
    logic [HS_TO_W-1:0] tmr_val;

`ifdef HS_ARB_TIMEOUT_EN
    assign to_hit = tmr_exp;
`else
    assign to_hit = 1'b0;
`endif

    assign in_wait    = (state == HALT) ||
                        (state == WAIT_VBL);
    assign halt_entry = (state == IDLE) && hs_req;
    assign rel_entry  =
        (in_wait && (!hs_req || to_hit)) ||
        ((state == GRANT) && (!hs_req || !pause_ack));
    assign gnt_entry  = (state == WAIT_VBL) &&
                        !rel_entry && pause_ack && vblank;

    // Guard count is loaded on every way into RELEASE.
    assign tmr_load = halt_entry || rel_entry;
    assign tmr_val  = rel_entry ? GUARD_LD : TO_LD;

    hs_arb_timer #(.W(HS_TO_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .value   (tmr_val),
        .expired (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pause_req <= 1'b0;
            hs_gnt    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs_req) begin
                        state     <= HALT;
                        pause_req <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                HALT: begin
                    if (rel_entry) state <= RELEASE;
                    else if (pause_ack) state <= WAIT_VBL;
                end
                WAIT_VBL: begin
                    if (rel_entry) begin
                        state <= RELEASE;
                    end else if (!pause_ack) begin
                        state <= HALT;
                    end else if (gnt_entry) begin
                        state  <= GRANT;
                        hs_gnt <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rel_entry) begin
                        state  <= RELEASE;
                        hs_gnt <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (tmr_exp) begin
                        state     <= IDLE;
                        pause_req <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HS_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) timeout <= 1'b0;
        else if (gnt_entry) timeout <= 1'b0;
        else if (in_wait && to_hit) timeout <= 1'b1;
    end
`endif

    assign ram_addr  = hs_gnt ? hs_addr  : cpu_addr;
    assign ram_wdata = hs_gnt ? hs_wdata : cpu_wdata;
    assign ram_we    = hs_gnt ? hs_we    : cpu_we;

    logic          gnt_d;
    logic          rd_q;
    logic [DW-1:0] rdata_q;

    // Covers a read issued in the last GRANT cycle.
    assign hs_rvalid = gnt_d && rd_q;
    assign hs_rdata  = hs_rvalid ? ram_rdata : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_d   <= 1'b0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            gnt_d <= hs_gnt;
            rd_q  <= !hs_we;
            if (hs_rvalid) rdata_q <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed plus randomized bench for hs_ram_arbiter.
// Timeout checks are built when HS_ARB_TIMEOUT_EN is defined.
module tb_hs_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int G  = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic          hs_req;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata;
    logic          hs_we;
    logic          hs_gnt;
    logic [DW-1:0] hs_rdata;
    logic          hs_rvalid;
    logic          pause_req;
    logic          pause_ack;
    logic          vblank;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic          busy;
`ifdef HS_ARB_TIMEOUT_EN
    logic          timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] model [logic [AW-1:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    hs_ram_arbiter #(
        .AW(AW), .DW(DW), .GUARD(G), .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .hs_req    (hs_req),
        .hs_addr   (hs_addr),
        .hs_wdata  (hs_wdata),
        .hs_we     (hs_we),
        .hs_gnt    (hs_gnt),
        .hs_rdata  (hs_rdata),
        .hs_rvalid (hs_rvalid),
        .pause_req (pause_req),
        .pause_ack (pause_ack),
        .vblank    (vblank),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .busy      (busy)
`ifdef HS_ARB_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) break;
            step();
        end
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pause"}, pause_req, 0);
    endtask

    // One granted hiscore access, checked against the memory model.
    task automatic hs_op(input string tag,
                         input logic we,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        logic [DW-1:0] exp_d;
        hs_we    = we;
        hs_addr  = a;
        hs_wdata = d;
        #1;
        chk({tag, "_mux_addr"}, ram_addr, a);
        chk({tag, "_mux_we"}, ram_we, we);
        exp_d = model.exists(a) ? model[a] : '0;
        step();
        chk({tag, "_rvalid"}, hs_rvalid, !we);
        if (!we) chk({tag, "_rdata"}, hs_rdata, exp_d);
        if (we) model[a] = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int gseen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        reset = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
        hs_req = 1'b0; hs_addr = '0;
        hs_wdata = '0; hs_we = 1'b0;
        pause_ack = 1'b0; vblank = 1'b0;
        step(); step();
        chk("rst_pause", pause_req, 0);
        chk("rst_gnt", hs_gnt, 0);
        chk("rst_rvalid", hs_rvalid, 0);
        chk("rst_rdata", hs_rdata, 0);
        chk("rst_busy", busy, 0);
`ifdef HS_ARB_TIMEOUT_EN
        chk("rst_timeout", timeout, 0);
`endif
        reset = 1'b0;
        step();

        cpu_addr = 12'h123; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        #1;
        chk("pt_addr", ram_addr, 12'h123);
        chk("pt_wdata", ram_wdata, 8'h5A);
        chk("pt_we", ram_we, 1);
        chk("pt_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            cpu_addr  = AW'($urandom);
            cpu_wdata = DW'($urandom);
            cpu_we    = 1'($urandom);
            hs_addr   = AW'($urandom);
            hs_we     = 1'($urandom);
            #1;
            chk("pt_rnd_addr", ram_addr, cpu_addr);
            chk("pt_rnd_we", ram_we, cpu_we);
            step();
        end
        cpu_we = 1'b0; hs_we = 1'b0;
        step();

        vblank = 1'b1; hs_req = 1'b1;
        step();
        chk("fg_pause", pause_req, 1);
        chk("fg_busy", busy, 1);
        chk("fg_gnt1", hs_gnt, 0);
        pause_ack = 1'b1;
        step();
        chk("fg_gnt2", hs_gnt, 0);
        step();
        chk("fg_gnt3", hs_gnt, 1);
        hs_op("fg_wr", 1'b1, 12'h0A0, 8'h42);
        hs_op("fg_rd", 1'b0, 12'h0A0, 8'h00);
        for (int i = 1; i < 8; i++)
            hs_op("pool_wr", 1'b1, AW'(12'h0A0 + i),
                  DW'($urandom));
        for (int i = 0; i < 24; i++) begin
            a = AW'(12'h0A0 + $urandom_range(0, 7));
            d = DW'($urandom);
            hs_op("rnd", 1'($urandom), a, d);
        end
        hs_op("last_rd", 1'b0, 12'h0A3, 8'h00);

        hs_req = 1'b0;
        hs_we  = 1'b0;
        hs_addr = 12'h0A5;
        d = model[12'h0A5];
        step();
        chk("rel_gnt", hs_gnt, 0);
        chk("rel_pause", pause_req, 1);
        chk("rel_tail_rvalid", hs_rvalid, 1);
        chk("rel_tail_rdata", hs_rdata, d);
        vblank = 1'b0;
        for (int k = 1; k < G; k++) begin
            if (k == 1) hs_req = 1'b1;
            step();
            chk("rel_hold_pause", pause_req, 1);
            chk("rel_hold_gnt", hs_gnt, 0);
        end
        step();
        chk("rel_end_pause", pause_req, 0);
        chk("rel_end_busy", busy, 0);

        step();
        chk("vw_pause", pause_req, 1);
        step();
        gseen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (hs_gnt !== 1'b0) gseen++;
        end
        chk("vw_no_gnt", gseen, 0);
        vblank = 1'b1;
        step();
        chk("vw_gnt", hs_gnt, 1);
        vblank = 1'b0;
        step();
        chk("vw_vbl_fall_gnt", hs_gnt, 1);
        pause_ack = 1'b0;
        step();
        chk("safe_gnt", hs_gnt, 0);
        chk("safe_pause", pause_req, 1);
        hs_req = 1'b0;
        wait_idle("safe_idle");

        hs_req = 1'b1;
        step();
        chk("ab_pause", pause_req, 1);
        step();
        hs_req = 1'b0; pause_ack = 1'b1; vblank = 1'b1;
        step();
        chk("ab_gnt", hs_gnt, 0);
        chk("ab_busy", busy, 1);
        gseen = 0;
        for (int k = 1; k < G; k++) begin
            step();
            if (hs_gnt !== 1'b0) gseen++;
        end
        chk("ab_never_gnt", gseen, 0);
        step();
        chk("ab_busy_end", busy, 0);

        hs_req = 1'b1;
        step(); step(); step();
        chk("rg_gnt", hs_gnt, 1);
        hs_op("rg_rd", 1'b0, 12'h0A1, 8'h00);
        reset = 1'b1;
        step();
        chk("rg_gnt0", hs_gnt, 0);
        chk("rg_pause0", pause_req, 0);
        chk("rg_busy0", busy, 0);
        chk("rg_rvalid0", hs_rvalid, 0);
        chk("rg_rdata0", hs_rdata, 0);
        reset = 1'b0; hs_req = 1'b0; pause_ack = 1'b0;
        step();

`ifdef HS_ARB_TIMEOUT_EN
        hs_req = 1'b1;
        step();
        chk("to_pause", pause_req, 1);
        gseen = 0;
        for (int i = 1; i < TO; i++) begin
            step();
            if (timeout !== 1'b0) gseen++;
        end
        chk("to_early", gseen, 0);
        step();
        chk("to_flag", timeout, 1);
        chk("to_gnt", hs_gnt, 0);
        hs_req = 1'b0;
        wait_idle("to_idle");
        chk("to_sticky", timeout, 1);
        hs_req = 1'b1; pause_ack = 1'b1; vblank = 1'b1;
        step(); step(); step();
        chk("to_regnt", hs_gnt, 1);
        chk("to_clear", timeout, 0);
        hs_req = 1'b0;
        wait_idle("to_idle2");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
